// File: rtl/mlp_pkg.sv
// Shared MLP definitions: fp32 type, ordering key and argmax FSM states.
package mlp_pkg;

    localparam int N_CLASSES = 10;

    typedef logic [31:0] fp32_t;

    localparam logic [7:0] FP32_EXP_ONES = 8'hFF;
    localparam fp32_t      FP32_NEG_ZERO = 32'h8000_0000;
    // Any NaN maps to key 0, so a NaN seed acts as the "minimum" best value.
    localparam fp32_t      FP32_QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Monotonic unsigned key: NaN lowest, -0 folded onto +0, Inf ordered normally.
    function automatic fp32_t fp32_order_key(input fp32_t x);
        fp32_t key;
        if (x[30:23] == FP32_EXP_ONES && x[22:0] != 23'd0)
            key = '0;
        else if (x == FP32_NEG_ZERO)
            key = 32'h8000_0000;
        else if (x[31])
            key = ~x;
        else
            key = x ^ 32'h8000_0000;
        return key;
    endfunction

endpackage

// File: rtl/fp32_max_cmp.sv
// Combinational fp32 strict greater-than using the shared ordering key.
module fp32_max_cmp
    import mlp_pkg::*;
(
    input  fp32_t i_a,
    input  fp32_t i_b,
    output logic  o_a_gt_b
);

    assign o_a_gt_b = fp32_order_key(i_a) > fp32_order_key(i_b);

endmodule

// File: rtl/mlp_argmax.sv
// Sequential argmax over the output-layer fp32 scores, one compare per cycle.
module mlp_argmax #(
    parameter int N_CLASSES = mlp_pkg::N_CLASSES,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 4
) (
    input  logic                                CLK,
    input  logic                                reset,
    input  logic [0:N_CLASSES-1][DATA_W-1:0]    scores,
    input  logic                                layer_end,
    output logic [IDX_W-1:0]                    result,
    output logic [DATA_W-1:0]                   max_score,
    output logic                                valid,
    output logic                                busy
);
    import mlp_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    state_t              r_state;
    logic                r_le_q;
    logic [DATA_W-1:0]   r_snap [0:N_CLASSES-1];
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_best_idx;
    logic [DATA_W-1:0]   r_best_val;
    logic [IDX_W-1:0]    r_result;
    logic [DATA_W-1:0]   r_max_score;
    logic                r_valid;
    logic                r_busy;

    logic                w_start;
    logic                w_gt;
    logic [DATA_W-1:0]   w_cur;

    assign w_start = layer_end & ~r_le_q;
    assign w_cur   = r_snap[r_idx];

    assign result    = r_result;
    assign max_score = r_max_score;
    assign valid     = r_valid;
    assign busy      = r_busy;

    // Current snapshot entry vs running best; strict so ties keep the lower index.
    fp32_max_cmp u_cmp (
        .i_a      (w_cur),
        .i_b      (r_best_val),
        .o_a_gt_b (w_gt)
    );

    // Edge detector: always tracks layer_end so edges seen while busy are consumed.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) r_le_q <= 1'b0;
        else        r_le_q <= layer_end;
    end

    // IDLE/SCAN/DONE control, snapshot capture, running best and result registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_best_idx  <= '0;
            r_best_val  <= '0;
            r_result    <= '0;
            r_max_score <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < N_CLASSES; i++) r_snap[i] <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        for (int i = 0; i < N_CLASSES; i++) r_snap[i] <= scores[i];
                        r_idx      <= '0;
                        r_best_idx <= '0;
                        r_best_val <= FP32_QNAN;
                        r_busy     <= 1'b1;
                        r_valid    <= 1'b0;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_gt) begin
                        r_best_idx <= r_idx;
                        r_best_val <= w_cur;
                    end
                    if (r_idx == LAST_IDX) r_state <= DONE;
                    else                   r_idx   <= r_idx + 1'b1;
                end
                DONE: begin
                    r_result    <= r_best_idx;
                    r_max_score <= r_snap[r_best_idx];
                    r_valid     <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_argmax.sv
// Self-checking bench for mlp_argmax: scoreboard of expected classifications.
module tb_mlp_argmax;

    localparam int N  = 10;
    localparam int DW = 32;
    localparam int IW = 4;

    logic                   CLK = 1'b0;
    logic                   reset;
    logic [0:N-1][DW-1:0]   scores;
    logic                   layer_end;
    logic [IW-1:0]          result;
    logic [DW-1:0]          max_score;
    logic                   valid;
    logic                   busy;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mlp_argmax #(.N_CLASSES(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .scores    (scores),
        .layer_end (layer_end),
        .result    (result),
        .max_score (max_score),
        .valid     (valid),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: every rising valid must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result got idx=%0d score=%h want none", result, max_score);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (result !== mon_e.idx) begin
                    errors++;
                    $display("FAIL result got=%0d want=%0d", result, mon_e.idx);
                end
                checks++;
                if (max_score !== mon_e.val) begin
                    errors++;
                    $display("FAIL max_score got=%h want=%h", max_score, mon_e.val);
                end
            end
        end
        prev_valid <= valid;
    end

    task automatic fill(input logic [DW-1:0] v);
        for (int i = 0; i < N; i++) scores[i] = v;
    endtask

    // Drives a fresh 0->1 on layer_end; the following posedge samples the start.
    task automatic pulse_start();
        @(negedge CLK) layer_end = 1'b0;
        @(negedge CLK) layer_end = 1'b1;
    endtask

    // Measures negedges until valid is seen (41 means it never came).
    task automatic wait_valid(output int cyc, output int bcyc);
        cyc = 41; bcyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (busy) bcyc++;
            if (valid) begin cyc = c; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; layer_end = 1'b0; fill(32'h0);
        #12;
        checks++;
        if ({result, max_score, valid, busy} !== '0) begin
            errors++;
            $display("FAIL reset_state got r=%0d s=%h v=%b b=%b want all 0", result, max_score, valid, busy);
        end
        @(negedge CLK) reset = 1'b1;
    endtask

    task automatic test_basic();
        int c, b;
        fill(32'h3F80_0000); scores[7] = 32'h4000_0000;
        exp_q.push_back('{idx: 4'd7, val: 32'h4000_0000});
        pulse_start();
        wait_valid(c, b);
        checks++;
        if (c != 12) begin errors++; $display("FAIL basic_latency got=%0d want=12", c); end
        checks++;
        if (b != 11) begin errors++; $display("FAIL basic_busy_cycles got=%0d want=11", b); end
    endtask

    task automatic test_ties();
        int c, b;
        fill(32'h3F80_0000); scores[3] = 32'h4040_0000; scores[8] = 32'h4040_0000;
        exp_q.push_back('{idx: 4'd3, val: 32'h4040_0000});
        pulse_start();
        @(negedge CLK);
        checks++;
        if (valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_clears_valid got v=%b b=%b want v=0 b=1", valid, busy);
        end
        wait_valid(c, b);
        checks++;
        if (c != 11) begin errors++; $display("FAIL ties_latency got=%0d want=11", c); end
    endtask

    task automatic test_specials();
        int c, b;
        fill(32'hC000_0000);
        scores[0] = 32'hBF80_0000; scores[1] = 32'h8000_0000; scores[2] = 32'h7FC0_0000;
        exp_q.push_back('{idx: 4'd1, val: 32'h8000_0000});
        pulse_start();
        wait_valid(c, b);
        checks++;
        if (c != 12) begin errors++; $display("FAIL specials_latency got=%0d want=12", c); end
        scores[5] = 32'h7F80_0000;
        exp_q.push_back('{idx: 4'd5, val: 32'h7F80_0000});
        pulse_start();
        wait_valid(c, b);
        checks++;
        if (c != 12) begin errors++; $display("FAIL inf_latency got=%0d want=12", c); end
    endtask

    task automatic test_hold_high();
        int bad = 0;
        repeat (20) begin
            @(negedge CLK);
            if (busy !== 1'b0 || valid !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hold_high bad_cycles got=%0d want=0", bad); end
    endtask

    task automatic test_retrigger_midscan();
        int c, b, bad;
        fill(32'h3F80_0000); scores[7] = 32'h4000_0000;
        exp_q.push_back('{idx: 4'd7, val: 32'h4000_0000});
        pulse_start();
        repeat (3) @(negedge CLK);
        layer_end = 1'b0;
        fill(32'h0); scores[2] = 32'h4100_0000;
        @(negedge CLK) layer_end = 1'b1;
        wait_valid(c, b);
        checks++;
        if (c != 8) begin errors++; $display("FAIL retrigger_latency got=%0d want=8", c); end
        bad = 0;
        repeat (15) begin
            @(negedge CLK);
            if (busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL retrigger_queued busy_cycles got=%0d want=0", bad); end
    endtask

    task automatic test_async_reset();
        int c, b;
        fill(32'h3F80_0000); scores[4] = 32'h4080_0000;
        pulse_start();
        repeat (5) @(negedge CLK);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({result, max_score, valid, busy} !== '0) begin
            errors++;
            $display("FAIL async_reset got r=%0d s=%h v=%b b=%b want all 0", result, max_score, valid, busy);
        end
        layer_end = 1'b0;
        @(negedge CLK) reset = 1'b1;
        fill(32'hC000_0000); scores[5] = 32'h7F80_0000;
        exp_q.push_back('{idx: 4'd5, val: 32'h7F80_0000});
        pulse_start();
        wait_valid(c, b);
        checks++;
        if (c != 12) begin errors++; $display("FAIL post_reset_latency got=%0d want=12", c); end
    endtask

    task automatic test_all_nan();
        int c, b;
        fill(32'h7FC0_0000);
        exp_q.push_back('{idx: 4'd0, val: 32'h7FC0_0000});
        pulse_start();
        wait_valid(c, b);
        checks++;
        if (c != 12) begin errors++; $display("FAIL all_nan_latency got=%0d want=12", c); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_specials();
        test_hold_high();
        test_retrigger_midscan();
        test_async_reset();
        test_all_nan();
        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results got=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mlp_argmax.md
Name: mlp_argmax

Overview:
Reader at the output end of the MLP. It consumes the 10 fp32 class scores from the output layer when the layer signals completion, and scans them sequentially. It produces the winning class index and its score as the network's classification result. It sits directly after the output layer, driven by that layer's end flag, and replaces any consumer-side argmax logic.

Parameters:
N_CLASSES, 10, number of scores scanned (≥2).
DATA_W, 32, score width, IEEE-754 single precision.
IDX_W, 4, width of class index; must satisfy 2**IDX_W ≥ N_CLASSES.

Ports:
CLK  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-low reset.
scores  input  DATA_W x [0:N_CLASSES-1]  fp32 scores from output layer.
layer_end  input  1  output-layer completion flag (level, may stay high).
result  output  IDX_W  index of maximum score.
max_score  output  DATA_W  fp32 value of the winning score.
valid  output  1  result/max_score hold a completed classification.
busy  output  1  scan in progress.

Behaviour:
- Reset (reset=0, async): state IDLE; result=0, max_score=0, valid=0, busy=0, edge-detect register=0, snapshot cleared.
- Start = rising edge of layer_end (registered layer_end was 0, current 1). A level held high does not retrigger. Start is required again after layer_end falls and rises.
- FSM IDLE/SCAN/DONE:
  IDLE: on start, snapshot all scores into an internal array, idx←0, best_key←minimum, best_idx←0, busy←1, valid←0, go to SCAN.
  SCAN: one score per cycle. Compare key(snap[idx]) > best_key (strict), then update best. At idx=N_CLASSES-1, go to DONE next.
  DONE: register result←best_idx, max_score←snap[best_idx], valid←1, busy←0, go to IDLE.
- Latency: start sampled at edge k. Compares occur at edges k+1..k+N_CLASSES. valid rises at edge k+N_CLASSES+1, which is 12 cycles for the default.
- valid is sticky: it holds with result/max_score until the next start, which clears valid at the same edge busy rises.
- Start while busy (SCAN/DONE): ignored. The edge is consumed, not queued.
- Input changes during SCAN have no effect; only the snapshot is used.
- Ordering key (combinational): NaN (exp=0xFF, mant≠0) maps to key 0, the lowest, so it never wins unless all scores are NaN. -0 (0x80000000) is treated as +0. Otherwise, negative values give key = ~x and non-negative values give key = x ^ 0x80000000. Keys are compared unsigned. ±Inf are ordered normally.
- Ties: the lowest index wins, because replacement only happens on strict greater.
- All NaN: result=0, max_score=snap[0].
- reset asserted mid-SCAN: immediate return to reset values. No partial result is exposed.

Decomposition:
- Shared package mlp_pkg: N_CLASSES, fp32_t typedef (32-bit), FP32_EXP_ONES constant, fp32_order_key function, and a state enum {IDLE,SCAN,DONE}. The function may also be used by future layer logic.
- One sub-module: fp32_max_cmp, a combinational comparator (a, b → a_gt_b) that wraps fp32_order_key. It is instantiated once in the scan datapath.

Test Plan:
- Reset then scores={0x3F800000×9, 0x40000000 at idx 7}, layer_end 0→1 → busy 1 for 11 cycles; valid=1 at cycle 12 with result=7, max_score=0x40000000.
- Ties: scores all 0x3F800000 except idx 3 and 8 = 0x40400000 (3.0) → result=3, max_score=0x40400000.
- Negatives and specials: idx0=0xBF800000 (-1), idx1=0x80000000 (-0), idx2=0x7FC00000 (NaN), others 0xC0000000 (-2) → result=1, max_score=0x80000000. Then set idx5=0x7F800000 (+Inf) and retrigger → result=5.
- Retrigger rules: hold layer_end high after completion → no new scan, valid stays 1. Pulse layer_end at cycle 3 of a scan → ignored, and the final result reflects the first snapshot. Change scores mid-scan → result unchanged.
- Async reset at cycle 5 of a scan (reset=0 between clock edges) → outputs zero immediately. After release, a new start produces a correct result in 12 cycles.
- All NaN scores (0x7FC00000) → result=0, max_score=0x7FC00000, valid=1.
